// File: rtl/dff_mon_pkg.sv
// Shared types and helpers for the dff edge monitor.
//   state_t  : debounce FSM states
//   EVT_*    : event type encodings carried by the event slot
//   sat_inc  : saturating increment for counters up to 32 bits wide
package dff_mon_pkg;

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  localparam logic EVT_FALL = 1'b0;
  localparam logic EVT_RISE = 1'b1;

  // Increments value by one, holding at the all-ones value of a
  // width-bit counter instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/dff_mon_evt_slot.sv
// One-entry valid/ready event holding register.
//   clk, rst_l  : clock, asynchronous active-low reset
//   clear       : synchronous drop of held event and overflow flag
//   load        : new event offered this cycle, type in load_type
//   ready       : consumer accepts the held event
//   valid       : slot holds an event, type in evt_type
//   overflow    : sticky, set when an event arrived while the slot was full
module dff_mon_evt_slot
  import dff_mon_pkg::*;
(
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic load,
  input  logic load_type,
  input  logic ready,
  output logic valid,
  output logic evt_type,
  output logic overflow
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      valid    <= 1'b0;
      evt_type <= EVT_FALL;
      overflow <= 1'b0;
    end else if (clear) begin
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      // A transfer on this edge frees the slot for the incoming event.
      if (!valid || ready) begin
        valid    <= 1'b1;
        evt_type <= load_type;
      end else begin
        overflow <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dff_edge_monitor.sv
// Debounces the registered dff level and reports qualified edges.
//   clk, rst_l            : clock, asynchronous active-low reset
//   q_in                  : level from upstream dff q
//   clear                 : synchronous clear of counters, overflow, event slot
//   level_out             : debounced level
//   rise_pulse/fall_pulse : one-cycle pulses on accepted transitions
//   rise_cnt/fall_cnt     : saturating accepted-edge counters
//   glitch_cnt            : saturating rejected-transition counter
//   evt_valid/evt_type/evt_ready : one-entry event slot handshake
//   overflow              : sticky dropped-event flag
module dff_edge_monitor
  import dff_mon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             q_in,
  input  logic             clear,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic             evt_valid,
  output logic             evt_type,
  input  logic             evt_ready,
  output logic             overflow
);

  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  logic       q_s;
  logic [7:0] stab_cnt;
  state_t     state;
  state_t     state_nxt;
  logic       rise_evt;
  logic       fall_evt;
  logic       glitch_evt;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) q_s <= 1'b0;
    else        q_s <= q_in;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state <= LOW;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOW:       if (q_s) state_nxt = WAIT_HIGH;
      WAIT_HIGH: if (!q_s) state_nxt = LOW;
                 else if (stab_cnt == STAB_LAST) state_nxt = HIGH;
      HIGH:      if (!q_s) state_nxt = WAIT_LOW;
      WAIT_LOW:  if (q_s) state_nxt = HIGH;
                 else if (stab_cnt == STAB_LAST) state_nxt = LOW;
      default:   state_nxt = LOW;
    endcase
  end

  always_comb begin
    rise_evt   = (state == WAIT_HIGH) && q_s && (stab_cnt == STAB_LAST);
    fall_evt   = (state == WAIT_LOW) && !q_s && (stab_cnt == STAB_LAST);
    glitch_evt = ((state == WAIT_HIGH) && !q_s) || ((state == WAIT_LOW) && q_s);
  end

  // Level is high while settled high or while a fall is still being qualified.
  assign level_out = (state == HIGH) || (state == WAIT_LOW);

  // stab_cnt counts samples of the candidate level already seen.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      stab_cnt <= '0;
    end else if ((state == LOW && q_s) || (state == HIGH && !q_s)) begin
      stab_cnt <= 8'd1;
    end else if ((state == WAIT_HIGH || state == WAIT_LOW) && state_nxt == state) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_evt;
      fall_pulse <= fall_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      glitch_cnt <= '0;
    end else if (clear) begin
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      if (rise_evt)   rise_cnt   <= CNT_W'(sat_inc(32'(rise_cnt), CNT_W));
      if (fall_evt)   fall_cnt   <= CNT_W'(sat_inc(32'(fall_cnt), CNT_W));
      if (glitch_evt) glitch_cnt <= CNT_W'(sat_inc(32'(glitch_cnt), CNT_W));
    end
  end

  dff_mon_evt_slot u_evt_slot (
    .clk       (clk),
    .rst_l     (rst_l),
    .clear     (clear),
    .load      (rise_evt || fall_evt),
    .load_type (rise_evt ? EVT_RISE : EVT_FALL),
    .ready     (evt_ready),
    .valid     (evt_valid),
    .evt_type  (evt_type),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_dff_edge_monitor.sv
module tb_dff_edge_monitor;

  localparam int S    = 4;
  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_l = 1'b0;
  logic         q_in = 1'b1;
  logic         clear = 1'b0;
  logic         evt_ready = 1'b0;
  logic         level_out, rise_pulse, fall_pulse;
  logic [W-1:0] rise_cnt, fall_cnt, glitch_cnt;
  logic         evt_valid, evt_type, overflow;

  int checks = 0;
  int fails  = 0;

  // Reference model: run-length view of the sample stream.
  bit m_qs, m_level, m_ovf;
  int m_run, m_rise, m_fall, m_glitch;
  bit slot_q[$];
  bit pulse_q[$];

  always #10 clk = ~clk;

  dff_edge_monitor #(.STABLE_CYCLES(S), .CNT_W(W)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .q_in       (q_in),
    .clear      (clear),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_cnt   (rise_cnt),
    .fall_cnt   (fall_cnt),
    .glitch_cnt (glitch_cnt),
    .evt_valid  (evt_valid),
    .evt_type   (evt_type),
    .evt_ready  (evt_ready),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_qs = 0; m_level = 0; m_ovf = 0;
    m_run = 0; m_rise = 0; m_fall = 0; m_glitch = 0;
    slot_q.delete();
    pulse_q.delete();
  endtask

  // Called at each rising edge with the inputs the DUT is sampling.
  task automatic model_step();
    bit accept = 0;
    bit glitch = 0;
    if (m_qs != m_level) begin
      m_run++;
      if (m_run == S) begin
        m_level = m_qs;
        accept  = 1;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0) glitch = 1;
      m_run = 0;
    end
    if (accept) pulse_q.push_back(m_level);
    if (clear) begin
      m_rise = 0; m_fall = 0; m_glitch = 0; m_ovf = 0;
      slot_q.delete();
    end else begin
      if (accept && m_level && m_rise < MAXC) m_rise++;
      if (accept && !m_level && m_fall < MAXC) m_fall++;
      if (glitch && m_glitch < MAXC) m_glitch++;
      if (slot_q.size() > 0 && evt_ready) void'(slot_q.pop_front());
      if (accept) begin
        if (slot_q.size() == 0) slot_q.push_back(m_level);
        else m_ovf = 1;
      end
    end
    m_qs = q_in;
  endtask

  task automatic step(input bit q, input bit rdy, input bit clr);
    q_in = q; evt_ready = rdy; clear = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"},  level_out, 0);
    check({tag, "_rpulse"}, rise_pulse, 0);
    check({tag, "_fpulse"}, fall_pulse, 0);
    check({tag, "_rcnt"},   rise_cnt, 0);
    check({tag, "_fcnt"},   fall_cnt, 0);
    check({tag, "_gcnt"},   glitch_cnt, 0);
    check({tag, "_valid"},  evt_valid, 0);
    check({tag, "_type"},   evt_type, 0);
    check({tag, "_ovf"},    overflow, 0);
  endtask

  // Monitor: compares DUT outputs against the model mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      check("mon_level", level_out, m_level);
      check("mon_rise_cnt", rise_cnt, m_rise);
      check("mon_fall_cnt", fall_cnt, m_fall);
      check("mon_glitch_cnt", glitch_cnt, m_glitch);
      check("mon_overflow", overflow, m_ovf);
      check("mon_evt_valid", evt_valid, slot_q.size() != 0);
      if (evt_valid && slot_q.size() != 0) check("mon_evt_type", evt_type, slot_q[0]);
      if (pulse_q.size() != 0) begin
        bit t;
        t = pulse_q.pop_front();
        check("mon_pulse", {rise_pulse, fall_pulse}, t ? 2'b10 : 2'b01);
      end else begin
        check("mon_no_pulse", {rise_pulse, fall_pulse}, 2'b00);
      end
    end
  end

  initial begin
    model_reset();
    // 1. Reset with q_in high, then clean rise.
    repeat (2) @(posedge clk);
    #3;
    check_all_zero("rst");
    rst_l = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1, 0, 0);
      check("s1_rise_timing", rise_pulse, e == 5);
    end
    check("s1_level", level_out, 1);
    check("s1_rise_cnt", rise_cnt, 1);
    check("s1_valid", evt_valid, 1);
    check("s1_type", evt_type, 1);

    // Drain, fall, clear.
    step(1, 1, 0);
    check("s1_drain", evt_valid, 0);
    repeat (6) step(0, 1, 0);
    step(0, 1, 1);
    check("clr_fall_cnt", fall_cnt, 0);

    // 2. Glitch while LOW.
    step(1, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    check("s2_level", level_out, 0);
    check("s2_glitch_cnt", glitch_cnt, 1);
    check("s2_valid", evt_valid, 0);
    check("s2_rise_cnt", rise_cnt, 0);

    // 3. Backpressure: rise then fall with no consumer.
    repeat (6) step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    check("s3_type", evt_type, 1);
    check("s3_ovf", overflow, 1);
    check("s3_fall_cnt", fall_cnt, 1);
    check("s3_valid", evt_valid, 1);
    step(0, 1, 0);
    check("s3_drain", evt_valid, 0);

    // 4. Transfer on the same edge as a new fall.
    step(0, 0, 1);
    repeat (6) step(1, 0, 0);
    for (int e = 1; e <= 5; e++) step(0, e == 5, 0);
    check("s4_fall_pulse", fall_pulse, 1);
    check("s4_valid", evt_valid, 1);
    check("s4_type", evt_type, 0);
    check("s4_ovf", overflow, 0);
    step(0, 1, 0);

    // 5. Saturation then clear while high.
    for (int i = 0; i < 260; i++) begin
      repeat (5) step(1, 1, 0);
      repeat (5) step(0, 1, 0);
    end
    check("s5_rise_sat", rise_cnt, 255);
    check("s5_fall_sat", fall_cnt, 255);
    repeat (5) step(1, 1, 0);
    check("s5_rise_hold", rise_cnt, 255);
    step(1, 1, 1);
    check("s5_clr_rise", rise_cnt, 0);
    check("s5_clr_fall", fall_cnt, 0);
    check("s5_clr_ovf", overflow, 0);
    check("s5_level_kept", level_out, 1);

    // 6. Asynchronous reset while qualifying a rise.
    repeat (6) step(0, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("s6_pre_fall_cnt", fall_cnt, 1);
    check("s6_pre_valid", evt_valid, 1);
    #5;
    rst_l = 1'b0;
    model_reset();
    #1;
    check_all_zero("arst");
    @(posedge clk);
    #3;
    rst_l = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1, 0, 0);
      check("s6_rise_timing", rise_pulse, e == 5);
    end

    // 7. Random runs with random backpressure and occasional clear.
    for (int b = 0; b < 400; b++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++)
        step(v, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
    end
    repeat (3) step(0, 1, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
